button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Input-side companion to the LED output driver. Takes a raw, asynchronous,
//  bouncing push-button signal; synchronises, debounces and edge-detects it.
//  Produces a clean level plus single-cycle press/release strobes for control
//  logic, e.g. resetting or pausing the blink counter.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable synced samples needed to accept a change (>=2)
//  LONG_CYCLES      64  held cycles after accepted press before long-press strobe
//  CNT_W            7   counter width; requires 2**CNT_W > max(DEBOUNCE_CYCLES, LONG_CYCLES)
// PORTS
//  clk              in   1  system clock
//  i_reset          in   1  synchronous, active-high reset
//  i_btn            in   1  raw button, active-high, asynchronous to clk, may bounce
//  o_btn_level      out  1  debounced button level
//  o_press_pulse    out  1  one-cycle strobe when o_btn_level rises
//  o_release_pulse  out  1  one-cycle strobe when o_btn_level falls
//  o_long_pulse     out  1  one-cycle long-press strobe (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: sync flops=0, state=S_IDLE, counters=0, all outputs 0. Reset has
//    priority over every other event. A reset mid-debounce abandons the change.
//  - Synchroniser: 2 flops (i_btn -> s1 -> s2). Only s2 feeds the FSM.
//  - FSM states (encodings in package):
//    S_IDLE     level=0; s2==1 -> S_PRESS_CHK, cnt=1.
//    S_PRESS_CHK  s2==0 -> S_IDLE, cnt=0 (bounce rejected); s2==1 & cnt==DEBOUNCE_CYCLES-1
//               -> S_HELD, level<=1, press_pulse<=1; else cnt++.
//    S_HELD     level=1; s2==0 -> S_REL_CHK, cnt=1.
//    S_REL_CHK  s2==1 -> S_HELD, cnt=0; s2==0 & cnt==DEBOUNCE_CYCLES-1
//               -> S_IDLE, level<=0, release_pulse<=1; else cnt++.
//  - All outputs registered. Latency: i_btn stable from edge k -> o_btn_level and
//    strobe change at edge k+DEBOUNCE_CYCLES+1; strobe high exactly 1 cycle.
//  - Any opposite s2 sample during a CHK state restarts the count. No partial credit.
//  - Press and release strobes never assert in the same cycle. Strobes strictly
//    alternate, press first after reset.
//  - Button held through reset: level stays 0 after reset deasserts, then press
//    is accepted after a full debounce window. No phantom release.
//  - Counters saturate and never wrap. Width violation is a $error at elaboration.
// CONFIGURATION
//  Macro BUTTON_DEBOUNCE_LONGPRESS_EN.
//  - Defined: a second counter runs in S_HELD and clears on entry to S_HELD.
//    When it reaches LONG_CYCLES, o_long_pulse=1 for exactly one cycle, once per press.
//    The counter then saturates. Leaving S_HELD for S_REL_CHK pauses it; a return to
//    S_HELD from S_REL_CHK resumes it without clearing, so bounce does not retrigger.
//    A full release clears it.
//  - Undefined: no long counter logic; o_long_pulse tied 0. The port is always present.
// STRUCTURE
//  - Package button_pkg holds:
//    - state localparams S_IDLE/S_PRESS_CHK/S_HELD/S_REL_CHK (2-bit);
//    - default DEBOUNCE_CYCLES/LONG_CYCLES constants.
//  - Sub-module sync_2ff: generic 2-flop synchroniser with reset. It is reused for
//    any other asynchronous input.
//  - FSM, counters and output registers live in button_debounce.
// TESTING  (DEBOUNCE_CYCLES=16, LONG_CYCLES=64)
//  1 Clean press: i_btn 0->1 at edge 10, held -> o_btn_level=1 and o_press_pulse
//    for 1 cycle at edge 27; no other strobes.
//  2 Bounce: toggle i_btn every 3 cycles for 40 cycles, then hold 1 -> exactly one
//    press strobe, 17 edges after the final stable edge.
//  3 Glitch reject: 1-cycle high pulse, and separately a 15-cycle high pulse, from
//    idle -> no level change and no strobes.
//  4 Release: after a press, drop i_btn for 20 cycles -> o_release_pulse once,
//    17 edges after the drop; level=0.
//  5 Reset mid-op: assert i_reset at count 10 of a press check, with i_btn held high
//    -> outputs 0 during reset; press strobe 17 edges after deassert.
//  6 Long press (macro on): hold 200 cycles -> one o_long_pulse 64 cycles after the
//    press strobe. With the macro off, o_long_pulse stays 0 throughout.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button debouncer.
package button_pkg;

  // Debounce FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEFAULT_LONG_CYCLES     = 64;
  localparam int unsigned DEFAULT_CNT_W           = 7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, synchronous reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Two back-to-back flops to resolve metastability
  always_ff @(posedge clk) begin
    if (i_reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_d;
      s2 <= s1;
    end
  end

  assign o_q = s2;

endmodule

// File: rtl/button_debounce.sv
// Push-button synchroniser, debouncer and edge detector.
// Optional long-press strobe enabled by macro BUTTON_DEBOUNCE_LONGPRESS_EN;
// without it o_long_pulse is tied low.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_btn_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse
);

  if (((2 ** CNT_W) <= max_u(DEBOUNCE_CYCLES, LONG_CYCLES)) || (DEBOUNCE_CYCLES < 2)) begin : g_param_check
    $error("button_debounce: CNT_W too small or DEBOUNCE_CYCLES < 2");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       btn_s2;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .i_reset (i_reset),
    .i_d     (i_btn),
    .o_q     (btn_s2)
  );

  // State, debounce counter and registered outputs
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state, debounce count and strobe generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        level_d = 1'b0;
        if (btn_s2) begin
          state_d = S_PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      S_PRESS_CHK: begin
        if (!btn_s2) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else if (cnt_q < DEB_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HELD: begin
        level_d = 1'b1;
        if (!btn_s2) begin
          state_d = S_REL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      S_REL_CHK: begin
        if (btn_s2) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else if (cnt_q < DEB_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign o_btn_level     = level_q;
  assign o_press_pulse   = press_q;
  assign o_release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] long_q, long_d;
  logic             long_pulse_q, long_pulse_d;

  // Long-press counter and strobe registers
  always_ff @(posedge clk) begin
    if (i_reset) begin
      long_q       <= '0;
      long_pulse_q <= 1'b0;
    end else begin
      long_q       <= long_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  // Count only while staying in S_HELD; a bounce through S_REL_CHK pauses
  // without clearing, so the once-per-press strobe cannot retrigger.
  always_comb begin
    long_d       = long_q;
    long_pulse_d = 1'b0;
    if ((state_q == S_PRESS_CHK) && (state_d == S_HELD)) begin
      long_d = '0;
    end else if ((state_q == S_REL_CHK) && (state_d == S_IDLE)) begin
      long_d = '0;
    end else if ((state_q == S_HELD) && (state_d == S_HELD)) begin
      if (long_q == LONG_LAST) begin
        long_d       = LONG_SAT;
        long_pulse_d = 1'b1;
      end else if (long_q < LONG_LAST) begin
        long_d = long_q + 1'b1;
      end
    end
  end

  assign o_long_pulse = long_pulse_q;
`else
  assign o_long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce (16-cycle debounce, 64-cycle long press).
module tb_button_debounce;

  logic clk = 1'b0;
  logic i_reset;
  logic i_btn;
  logic o_btn_level;
  logic o_press_pulse;
  logic o_release_pulse;
  logic o_long_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  int edge_no   = 0;
  int n_press   = 0;
  int n_release = 0;
  int n_long    = 0;
  int long_total = 0;
  int last_press = -1;
  int last_release = -1;
  int last_long = -1;
  int both_err  = 0;
  int alt_err   = 0;
  bit last_was_press = 1'b0;
  int k;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES (16),
    .LONG_CYCLES     (64),
    .CNT_W           (7)
  ) dut (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_btn           (i_btn),
    .o_btn_level     (o_btn_level),
    .o_press_pulse   (o_press_pulse),
    .o_release_pulse (o_release_pulse),
    .o_long_pulse    (o_long_pulse)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, sample outputs 1 time unit later and log strobes
  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
    if (o_press_pulse) begin
      n_press++;
      last_press = edge_no;
      if (last_was_press) alt_err++;
      last_was_press = 1'b1;
    end
    if (o_release_pulse) begin
      n_release++;
      last_release = edge_no;
      if (!last_was_press) alt_err++;
      last_was_press = 1'b0;
    end
    if (o_long_pulse) begin
      n_long++;
      long_total++;
      last_long = edge_no;
    end
    if (o_press_pulse && o_release_pulse) both_err++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    n_press = 0;
    n_release = 0;
    n_long = 0;
    last_press = -1;
    last_release = -1;
    last_long = -1;
  endtask

  initial begin
    i_reset = 1'b1;
    i_btn   = 1'b0;

    // Reset state
    ticks(3);
    check("reset_level",   int'(o_btn_level),     0);
    check("reset_press",   int'(o_press_pulse),   0);
    check("reset_release", int'(o_release_pulse), 0);
    check("reset_long",    int'(o_long_pulse),    0);
    i_reset = 1'b0;

    // Clean press: first sampled high at edge 10, accepted at edge 27
    while (edge_no < 9) tick();
    clear_counts();
    i_btn = 1'b1;
    while (edge_no < 26) tick();
    check("t1_level_before", int'(o_btn_level), 0);
    tick();
    check("t1_level_at27", int'(o_btn_level),   1);
    check("t1_press_at27", int'(o_press_pulse), 1);
    tick();
    check("t1_press_width", int'(o_press_pulse), 0);
    ticks(10);
    check("t1_n_press",   n_press,   1);
    check("t1_n_release", n_release, 0);

    // Release: accepted 17 edges after the drop is first sampled
    clear_counts();
    i_btn = 1'b0;
    k = edge_no + 1;
    ticks(20);
    check("t4_n_release",    n_release,    1);
    check("t4_release_edge", last_release, k + 17);
    check("t4_level",        int'(o_btn_level), 0);
    check("t4_n_press",      n_press,      0);

    // Bounce: 14 toggles every 3 cycles, then stable high
    clear_counts();
    for (int i = 0; i < 14; i++) begin
      i_btn = ~i_btn;
      ticks(3);
    end
    i_btn = 1'b1;
    k = edge_no + 1;
    ticks(30);
    check("t2_n_press",    n_press,    1);
    check("t2_press_edge", last_press, k + 17);
    check("t2_n_release",  n_release,  0);
    check("t2_level",      int'(o_btn_level), 1);

    // Return to idle before glitch tests
    i_btn = 1'b0;
    ticks(25);
    check("t2_release_back", int'(o_btn_level), 0);

    // Glitch reject: 1-cycle and 15-cycle high pulses
    clear_counts();
    i_btn = 1'b1;
    tick();
    i_btn = 1'b0;
    ticks(25);
    check("t3_short_level", int'(o_btn_level), 0);
    i_btn = 1'b1;
    ticks(15);
    i_btn = 1'b0;
    ticks(25);
    check("t3_level",     int'(o_btn_level), 0);
    check("t3_n_press",   n_press,   0);
    check("t3_n_release", n_release, 0);

    // Reset at debounce count 10 with button held high
    clear_counts();
    i_btn = 1'b1;
    ticks(12);
    i_reset = 1'b1;
    ticks(3);
    check("t5_rst_level", int'(o_btn_level),     0);
    check("t5_rst_press", int'(o_press_pulse),   0);
    check("t5_rst_rel",   int'(o_release_pulse), 0);
    i_reset = 1'b0;
    k = edge_no + 1;
    ticks(30);
    check("t5_n_press",    n_press,    1);
    check("t5_press_edge", last_press, k + 17);
    check("t5_n_release",  n_release,  0);
    check("t5_level",      int'(o_btn_level), 1);

    // Long press: keep holding
    ticks(200);
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    check("t6_n_long",    n_long,    1);
    check("t6_long_edge", last_long, last_press + 64);
`else
    check("t6_n_long",    long_total, 0);
`endif
    check("t6_level",   int'(o_btn_level), 1);
    check("t6_n_press", n_press, 1);

    // Global strobe properties
    check("no_same_cycle_strobes", both_err, 0);
    check("strobe_alternation",    alt_err,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
